// File: rtl/hash_table.sv
// Package hash_table: shared types and default widths for the hash-table
// client slice.
//   ht_opcode_t    - command opcode carried on the command path (2 bits)
//   ht_rescode_t   - result code returned by the table (3 bits)
//   HT_KEY_WIDTH   - default key width
//   HT_VALUE_WIDTH - default value width
package hash_table;

  localparam int unsigned HT_KEY_WIDTH   = 32;
  localparam int unsigned HT_VALUE_WIDTH = 16;

  typedef enum logic [1:0] {
    HT_SEARCH = 2'd0,
    HT_INSERT = 2'd1,
    HT_DELETE = 2'd2,
    HT_UPDATE = 2'd3
  } ht_opcode_t;

  typedef enum logic [2:0] {
    HT_OK        = 3'd0,
    HT_NOT_FOUND = 3'd1,
    HT_EXISTS    = 3'd2,
    HT_FULL      = 3'd3,
    HT_ERROR     = 3'd4
  } ht_rescode_t;

endpackage

// File: rtl/ht_mp_tag_fifo.sv
// ht_mp_tag_fifo: in-order FIFO of port tags, one entry per outstanding
// command.
//   clk_i / rst_i     - clock, asynchronous active-low reset (empties FIFO)
//   push_i / data_i   - write a tag (caller guarantees not full)
//   pop_i             - drop the head entry (caller guarantees not empty)
//   data_o            - head tag
//   full_o / empty_o  - occupancy flags
// A simultaneous push and pop leaves occupancy unchanged.
module ht_mp_tag_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_q, rd_q;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign data_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q[AW-1:0]] <= data_i;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (pop_i) rd_q <= rd_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ht_multi_port.sv
// ht_multi_port: merges PORTS client command streams onto one hash-table
// command port (round-robin, registered output) and routes table results
// back to the issuing port in order, using a tag FIFO of port indices.
//   clk_i, rst_i (async, active low)
//   cmd_*_i / cmd_ready_o      - per-port command channels (packed by port)
//   ht_cmd_*_o / ht_cmd_ready_i - merged command to the table
//   ht_res_*_i / ht_res_ready_o - result from the table
//   res_valid_o / res_*_o / res_ready_i - per-port results (fields broadcast)
//   err_orphan_o - sticky: a result arrived with nothing outstanding
//   stat_cnt_o   - per-port accepted-command counters (32 bits each)
// Build option: define HT_MP_STATS_EN to include the per-port counters;
// otherwise stat_cnt_o is tied to zero.
module ht_multi_port
  import hash_table::*;
#(
  parameter int unsigned PORTS       = 4,
  parameter int unsigned KEY_WIDTH   = HT_KEY_WIDTH,
  parameter int unsigned VALUE_WIDTH = HT_VALUE_WIDTH,
  parameter int unsigned TAG_DEPTH   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [PORTS-1:0]             cmd_valid_i,
  input  logic [PORTS*KEY_WIDTH-1:0]   cmd_key_i,
  input  logic [PORTS*VALUE_WIDTH-1:0] cmd_value_i,
  input  logic [PORTS*2-1:0]           cmd_opcode_i,
  output logic [PORTS-1:0]             cmd_ready_o,
  output logic                         ht_cmd_valid_o,
  output logic [KEY_WIDTH-1:0]         ht_cmd_key_o,
  output logic [VALUE_WIDTH-1:0]       ht_cmd_value_o,
  output ht_opcode_t                   ht_cmd_opcode_o,
  input  logic                         ht_cmd_ready_i,
  input  logic                         ht_res_valid_i,
  input  logic [KEY_WIDTH-1:0]         ht_res_key_i,
  input  logic [VALUE_WIDTH-1:0]       ht_res_value_i,
  input  ht_rescode_t                  ht_res_rescode_i,
  output logic                         ht_res_ready_o,
  output logic [PORTS-1:0]             res_valid_o,
  output logic [KEY_WIDTH-1:0]         res_key_o,
  output logic [VALUE_WIDTH-1:0]       res_value_o,
  output ht_rescode_t                  res_rescode_o,
  input  logic [PORTS-1:0]             res_ready_i,
  output logic                         err_orphan_o,
  output logic [PORTS*32-1:0]          stat_cnt_o
);

  localparam int unsigned IW = $clog2(PORTS);

  logic [IW-1:0]          ptr_q, ptr_d;
  logic [IW-1:0]          grant;
  logic                   found;
  logic                   can_accept;
  logic                   hs;
  logic                   out_valid_q;
  logic [KEY_WIDTH-1:0]   key_q;
  logic [VALUE_WIDTH-1:0] value_q;
  ht_opcode_t             op_q;
  logic                   orphan_q, orphan_d;
  logic                   fifo_full, fifo_empty, pop;
  logic [IW-1:0]          head;

  // Round-robin: first valid port at or after the pointer, wrapping.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    grant = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= (IW+1)'(PORTS)) sum = sum - (IW+1)'(PORTS);
      cand = sum[IW-1:0];
      if (!found && cmd_valid_i[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  // A full FIFO blocks granting even if a pop happens this cycle, so the
  // grant never depends on the result-side handshake. Gating with rst_i
  // keeps cmd_ready_o low while reset is held.
  assign can_accept  = rst_i && (!out_valid_q || ht_cmd_ready_i) && !fifo_full;
  assign hs          = found && can_accept;
  assign cmd_ready_o = hs ? (PORTS'(1) << grant) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) ptr_d = (grant == IW'(PORTS-1)) ? '0 : grant + IW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      key_q       <= '0;
      value_q     <= '0;
      op_q        <= HT_SEARCH;
      orphan_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      orphan_q <= orphan_d;
      if (hs) begin
        out_valid_q <= 1'b1;
        key_q       <= cmd_key_i[32'(grant)*KEY_WIDTH +: KEY_WIDTH];
        value_q     <= cmd_value_i[32'(grant)*VALUE_WIDTH +: VALUE_WIDTH];
        op_q        <= ht_opcode_t'(cmd_opcode_i[32'(grant)*2 +: 2]);
      end else if (ht_cmd_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign ht_cmd_valid_o  = out_valid_q;
  assign ht_cmd_key_o    = key_q;
  assign ht_cmd_value_o  = value_q;
  assign ht_cmd_opcode_o = op_q;

  ht_mp_tag_fifo #(
    .WIDTH (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (hs),
    .data_i  (grant),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Results with nothing outstanding are accepted and dropped.
  always_comb begin
    res_valid_o = '0;
    if (rst_i && !fifo_empty) res_valid_o[head] = ht_res_valid_i;
  end

  assign ht_res_ready_o = rst_i && (fifo_empty || res_ready_i[head]);
  assign pop            = ht_res_valid_i && ht_res_ready_o && !fifo_empty;
  assign orphan_d       = orphan_q || (ht_res_valid_i && fifo_empty);
  assign err_orphan_o   = orphan_q;

  assign res_key_o     = ht_res_key_i;
  assign res_value_o   = ht_res_value_i;
  assign res_rescode_o = ht_res_rescode_i;

`ifdef HT_MP_STATS_EN
  logic [31:0] cnt_q [PORTS];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned p = 0; p < PORTS; p++) cnt_q[p] <= '0;
    end else if (hs) begin
      cnt_q[grant] <= cnt_q[grant] + 32'd1;
    end
  end

  always_comb begin
    stat_cnt_o = '0;
    for (int unsigned p = 0; p < PORTS; p++) stat_cnt_o[p*32 +: 32] = cnt_q[p];
  end
`else
  assign stat_cnt_o = '0;
`endif

endmodule
